// File: rtl/vec_alu_engine_pkg.sv
// ---------------------------------------------------------------------------
// vec_alu_engine_pkg
// Shared constants for the vector ALU engine: opcode width and encodings,
// and the engine FSM state type.
// No ports (package).
// ---------------------------------------------------------------------------
package vec_alu_engine_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
    localparam logic [OP_W-1:0] OP_AND  = 3'd2;
    localparam logic [OP_W-1:0] OP_OR   = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_SLL  = 3'd5;
    localparam logic [OP_W-1:0] OP_SRL  = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/vec_alu_core.sv
// ---------------------------------------------------------------------------
// vec_alu_core
// Purely combinational DATA_W-bit ALU. The result register lives in the
// engine top; this block only selects the operation.
// Ports:
//   a, b    in  DATA_W  operands
//   op      in  OP_W    opcode (ADD, SUB, AND, OR, XOR, SLL, SRL, PASS_A)
//   result  out DATA_W  wrapped result (carries/borrows dropped)
// ---------------------------------------------------------------------------
module vec_alu_core
    import vec_alu_engine_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result
);

    // Shift amount is always the low five bits of B, independent of DATA_W.
    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        result = a;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLL:  result = a << shamt;
            OP_SRL:  result = a >> shamt;
            default: result = a;
        endcase
    end

endmodule

// File: rtl/vec_alu_engine.sv
// ---------------------------------------------------------------------------
// vec_alu_engine
// Vector ALU engine. The host loads vectors A, B and OP, then raises start_i;
// the engine streams elements 0..len-1 through a three-stage pipeline
// (address -> memory read -> ALU register -> O write) at one element/cycle.
// Optional feature macro: VEC_ALU_ACCUM_EN adds acc_o, the wrapping sum of
// every result written in the last run.
// Ports:
//   CLK          in   1         clock, all state on posedge
//   RST          in   1         asynchronous active-low reset
//   host_addr_i  in   ADDR_W    host address shared by all four memories
//   host_data_i  in   DATA_W    host write data (OP takes bits [2:0])
//   host_we_i    in   4         write strobes {O,OP,B,A}
//   host_re_i    in   1         read O at host_addr_i, data next cycle
//   host_data_o  out  DATA_W    registered O read data
//   len_i        in   ADDR_W+1  element count, clamped to DEPTH
//   start_i      in   1         level start request
//   busy_o       out  1         high in RUN and DRAIN
//   done_o       out  1         high in DONE
//   acc_o        out  DATA_W    (VEC_ALU_ACCUM_EN only) result accumulator
// ---------------------------------------------------------------------------
module vec_alu_engine
    import vec_alu_engine_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_data_i,
    input  logic [3:0]        host_we_i,
    input  logic              host_re_i,
    output logic [DATA_W-1:0] host_data_o,
    input  logic [ADDR_W:0]   len_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o
`ifdef VEC_ALU_ACCUM_EN
    ,
    output logic [DATA_W-1:0] acc_o
`endif
);

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

    // Memories (contents are never reset)
    logic [DATA_W-1:0] a_mem  [DEPTH];
    logic [DATA_W-1:0] b_mem  [DEPTH];
    logic [OP_W-1:0]   op_mem [DEPTH];
    logic [DATA_W-1:0] o_mem  [DEPTH];

    state_t            state_reg, state_next;
    logic [ADDR_W:0]   rd_ptr_reg;
    logic [ADDR_W:0]   len_reg;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic              rd_valid_reg;   // memory read data valid
    logic              res_valid_reg;  // ALU result register valid

    logic [DATA_W-1:0] a_rd_reg, b_rd_reg, res_reg, alu_out;
    logic [OP_W-1:0]   op_rd_reg;

    logic              busy;
    logic              accept;
    logic              last_issue;
    logic [ADDR_W:0]   len_clamped;
    logic [ADDR_W-1:0] mem_addr;
    logic              o_we;
    logic [ADDR_W-1:0] o_waddr;
    logic [DATA_W-1:0] o_wdata;

    assign busy        = (state_reg == S_RUN) || (state_reg == S_DRAIN);
    assign accept      = (state_reg == S_IDLE) && start_i;
    assign len_clamped = (len_i > LEN_MAX) ? LEN_MAX : len_i;
    // len_reg is never 0 while in RUN, so the subtraction cannot underflow there.
    assign last_issue  = (state_reg == S_RUN) && (rd_ptr_reg == len_reg - PTR_ONE);

    // Single port on A/B/OP: the engine owns the address while busy,
    // the host owns it otherwise.
    assign mem_addr = busy ? rd_ptr_reg[ADDR_W-1:0] : host_addr_i;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start_i) begin
                    state_next = (len_clamped == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_issue) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Both stages empty means the final O write has already happened.
                if (!rd_valid_reg && !res_valid_reg) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!start_i) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy_o = busy;
        done_o = (state_reg == S_DONE);
    end

    // ---------------- Pointers and pipeline valids ----------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            len_reg       <= '0;
            rd_valid_reg  <= 1'b0;
            res_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
                len_reg    <= len_clamped;
            end else begin
                // rd_ptr parks on the last address instead of wrapping.
                if ((state_reg == S_RUN) && !last_issue) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                end
                if (res_valid_reg) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
            end
            rd_valid_reg  <= (state_reg == S_RUN);
            res_valid_reg <= rd_valid_reg;
        end
    end

    // ---------------- Operand memories (registered read) ----------------
    always_ff @(posedge CLK) begin
        if (host_we_i[0] && !busy) begin
            a_mem[mem_addr] <= host_data_i;
        end
        a_rd_reg <= a_mem[mem_addr];
    end

    always_ff @(posedge CLK) begin
        if (host_we_i[1] && !busy) begin
            b_mem[mem_addr] <= host_data_i;
        end
        b_rd_reg <= b_mem[mem_addr];
    end

    always_ff @(posedge CLK) begin
        if (host_we_i[2] && !busy) begin
            op_mem[mem_addr] <= host_data_i[OP_W-1:0];
        end
        op_rd_reg <= op_mem[mem_addr];
    end

    // ---------------- ALU and result register ----------------
    vec_alu_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .a      (a_rd_reg),
        .b      (b_rd_reg),
        .op     (op_rd_reg),
        .result (alu_out)
    );

    always_ff @(posedge CLK) begin
        res_reg <= alu_out;
    end

    // ---------------- Result memory O ----------------
    // Engine writes only happen while busy and host writes only while idle,
    // so the mux never has to arbitrate a real collision.
    assign o_we    = res_valid_reg || (host_we_i[3] && !busy);
    assign o_waddr = res_valid_reg ? wr_ptr_reg : host_addr_i;
    assign o_wdata = res_valid_reg ? res_reg : host_data_i;

    always_ff @(posedge CLK) begin
        if (o_we) begin
            o_mem[o_waddr] <= o_wdata;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            host_data_o <= '0;
        end else if (host_re_i) begin
            host_data_o <= busy ? '0 : o_mem[host_addr_i];
        end
    end

`ifdef VEC_ALU_ACCUM_EN
    logic [DATA_W-1:0] acc_reg;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc_reg <= '0;
        end else if (accept) begin
            acc_reg <= '0;
        end else if (res_valid_reg) begin
            acc_reg <= acc_reg + res_reg;
        end
    end

    assign acc_o = acc_reg;
`endif

endmodule

// File: tb/tb_vec_alu_engine.sv
// ---------------------------------------------------------------------------
// tb_vec_alu_engine
// Directed bench for vec_alu_engine (DATA_W=32, DEPTH=64). Host reads of O
// push the expected word into a scoreboard queue and pop it when the
// registered read data appears. Build with VEC_ALU_ACCUM_EN to also check acc_o.
// ---------------------------------------------------------------------------
module tb_vec_alu_engine;
    import vec_alu_engine_pkg::*;

    localparam int DW  = 32;
    localparam int DEP = 64;
    localparam int AW  = 6;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [AW-1:0] host_addr_i = '0;
    logic [DW-1:0] host_data_i = '0;
    logic [3:0]    host_we_i = '0;
    logic          host_re_i = 1'b0;
    logic [DW-1:0] host_data_o;
    logic [AW:0]   len_i = '0;
    logic          start_i = 1'b0;
    logic          busy_o;
    logic          done_o;
`ifdef VEC_ALU_ACCUM_EN
    logic [DW-1:0] acc_o;
`endif

    always #5 CLK = ~CLK;

    vec_alu_engine #(
        .DATA_W (DW),
        .DEPTH  (DEP)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .host_addr_i (host_addr_i),
        .host_data_i (host_data_i),
        .host_we_i   (host_we_i),
        .host_re_i   (host_re_i),
        .host_data_o (host_data_o),
        .len_i       (len_i),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
`ifdef VEC_ALU_ACCUM_EN
        ,
        .acc_o       (acc_o)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] a_m  [DEP];
    logic [DW-1:0] b_m  [DEP];
    logic [2:0]    op_m [DEP];
    logic [DW-1:0] o_m  [DEP];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] acc_exp = '0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
        $display("[TB] %s obs=0x%08h exp=0x%08h", tag, obs, expv);
    endtask

    function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[4:0];
            3'd6:    return a >> b[4:0];
            default: return a;
        endcase
    endfunction

    // sel: 0=A 1=B 2=OP 3=O
    task automatic hwrite(input int sel, input int addr, input logic [DW-1:0] d);
        host_we_i   = 4'(1 << sel);
        host_addr_i = AW'(addr);
        host_data_i = d;
        @(posedge CLK); #1;
        host_we_i = '0;
        case (sel)
            0:       a_m[addr] = d;
            1:       b_m[addr] = d;
            2:       op_m[addr] = d[2:0];
            default: o_m[addr] = d;
        endcase
    endtask

    task automatic hread(input int addr, input string tag);
        logic [DW-1:0] e;
        host_addr_i = AW'(addr);
        host_re_i   = 1'b1;
        exp_q.push_back(o_m[addr]);
        @(posedge CLK); #1;
        host_re_i = 1'b0;
        e = exp_q.pop_front();
        check($sformatf("%s_O[%0d]", tag, addr), host_data_o, e);
    endtask

    // Starts a run of length L, waits for DONE (bounded), holds start_i for
    // 'hold' extra cycles, then releases it and checks the return to IDLE.
    task automatic run(input int L, input int hold, input string tag);
        int el;
        int cnt;
        el = (L > DEP) ? DEP : L;
        len_i   = (AW+1)'(L);
        start_i = 1'b1;
        @(posedge CLK); #1;
        if (el == 0) begin
            check({tag, "_len0_done"}, 32'(done_o), 32'd1);
            check({tag, "_len0_busy"}, 32'(busy_o), 32'd0);
            acc_exp = '0;
        end else begin
            check({tag, "_busy"}, 32'(busy_o), 32'd1);
            cnt = 0;
            while (!done_o && cnt < el + 50) begin
                @(posedge CLK); #1;
                cnt++;
            end
            check({tag, "_cycles"}, 32'(cnt), 32'(el + 3));
            check({tag, "_busy_at_done"}, 32'(busy_o), 32'd0);
            acc_exp = '0;
            for (int i = 0; i < el; i++) begin
                o_m[i]  = alu_ref(a_m[i], b_m[i], op_m[i]);
                acc_exp = acc_exp + o_m[i];
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge CLK); #1;
            check({tag, "_hold_done"}, 32'(done_o), 32'd1);
            check({tag, "_hold_busy"}, 32'(busy_o), 32'd0);
        end
        start_i = 1'b0;
        @(posedge CLK); #1;
        check({tag, "_idle_done"}, 32'(done_o), 32'd0);
`ifdef VEC_ALU_ACCUM_EN
        check({tag, "_acc"}, acc_o, acc_exp);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] t2 [8];
        int cnt;
        t2[0] = 32'hF0F0_0004; t2[1] = 32'hF0EF_FFFC; t2[2] = 32'h0000_0000; t2[3] = 32'hF0F0_0004;
        t2[4] = 32'hF0F0_0004; t2[5] = 32'h0F00_0000; t2[6] = 32'h0F0F_0000; t2[7] = 32'hF0F0_0000;

        // ---- reset ----
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_rdata", host_data_o, 32'd0);
`ifdef VEC_ALU_ACCUM_EN
        check("rst_acc", acc_o, 32'd0);
`endif
        RST = 1'b1;
        @(posedge CLK); #1;

        // ---- known O background ----
        for (int i = 0; i < DEP; i++) hwrite(3, i, 32'hA5A5_0000 | 32'(i));

        // ---- test 1: A[i]=i, B=1, ADD, len=8 ----
        for (int i = 0; i < 8; i++) begin
            hwrite(0, i, 32'(i));
            hwrite(1, i, 32'd1);
            hwrite(2, i, 32'(OP_ADD));
        end
        run(8, 0, "t1");
`ifdef VEC_ALU_ACCUM_EN
        check("t1_acc36", acc_o, 32'd36);
`endif
        for (int i = 0; i <= 8; i++) hread(i, "t1");

        // ---- test 2: mixed opcodes ----
        for (int i = 0; i < 8; i++) begin
            hwrite(0, i, 32'hF0F0_0000);
            hwrite(1, i, 32'h0000_0004);
            hwrite(2, i, 32'(i));
        end
        run(8, 0, "t2");
        for (int i = 0; i < 8; i++) o_m[i] = t2[i];
        for (int i = 0; i < 8; i++) hread(i, "t2");

        // ---- test 3a: len=0 leaves O untouched ----
        run(0, 0, "t3len0");
        hread(0, "t3len0");
        hread(7, "t3len0");

        // ---- test 4: host lock-out while busy ----
        hwrite(3, 40, 32'h0000_1234);
        hread(40, "t4pre");
        for (int i = 0; i < 8; i++) begin
            hwrite(0, i, 32'h0000_4000 + 32'(i));
            hwrite(2, i, 32'(OP_PASS));
        end
        len_i = 7'd8; start_i = 1'b1;
        @(posedge CLK); #1;
        check("t4_busy", 32'(busy_o), 32'd1);
        host_we_i = 4'b0001; host_addr_i = 6'd3; host_data_i = 32'hDEAD_DEAD;
        @(posedge CLK); #1;
        host_we_i = '0;
        host_re_i = 1'b1; host_addr_i = 6'd40;
        exp_q.push_back(32'd0);
        @(posedge CLK); #1;
        host_re_i = 1'b0;
        check("t4_busy_read", host_data_o, exp_q.pop_front());
        host_we_i = 4'b1000; host_addr_i = 6'd20; host_data_i = 32'hBEEF_BEEF;
        @(posedge CLK); #1;
        host_we_i = '0;
        cnt = 3;
        while (!done_o && cnt < 60) begin
            @(posedge CLK); #1;
            cnt++;
        end
        check("t4_cycles", 32'(cnt), 32'd11);
        start_i = 1'b0;
        @(posedge CLK); #1;
        for (int i = 0; i < 8; i++) o_m[i] = a_m[i];
        hread(3, "t4");
        hread(0, "t4");
        hread(20, "t4");
        hread(40, "t4");
        // Re-run to expose any stray operand write made during the busy window.
        run(8, 0, "t4b");
        for (int i = 0; i < 8; i++) hread(i, "t4b");

        // ---- test 5: reset mid-run ----
        for (int i = 0; i < 16; i++) begin
            hwrite(0, i, 32'h0000_0100 + 32'(i));
            hwrite(1, i, 32'(i));
            hwrite(2, i, 32'(OP_ADD));
        end
        len_i = 7'd16; start_i = 1'b1;
        @(posedge CLK); #1;
        repeat (4) begin
            @(posedge CLK); #1;
        end
        RST = 1'b0; start_i = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy_o), 32'd0);
        check("t5_rst_done", 32'(done_o), 32'd0);
        for (int i = 0; i < 2; i++) o_m[i] = alu_ref(a_m[i], b_m[i], op_m[i]);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        for (int i = 0; i < 16; i++) hread(i, "t5");
        run(16, 0, "t5re");
        for (int i = 0; i < 16; i++) hread(i, "t5re");

        // ---- test 6: start held through DONE ----
        run(4, 20, "t6");

        // ---- test 3b: full depth wrap, then clamp ----
        for (int i = 0; i < DEP; i++) begin
            hwrite(0, i, 32'hFFFF_FFFF);
            hwrite(1, i, 32'd1);
            hwrite(2, i, 32'(OP_ADD));
        end
        run(DEP, 0, "t3full");
        for (int i = 0; i < DEP; i++) hread(i, "t3full");
        run(DEP + 5, 0, "t3clamp");
        hread(DEP - 1, "t3clamp");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
